// File: rtl/rv_if_pkg.sv
// Shared definitions for the instruction-fetch stage: boot/limit/bubble
// defaults, fetch FSM state encoding and small address helpers.
package rv_if_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0400;
  localparam logic [31:0] IMEM_LIMIT_DEF = 32'h0000_1000;
  localparam logic [31:0] NOP_INST_DEF   = 32'h0000_0013;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  // Sequential successor of a fetch address; the carry is dropped so the
  // address space wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads a fetched word, holds on stall, or is
// overwritten with a bubble (NOP, invalid) on redirect or fetch fault.
module ifid_reg
  import rv_if_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] fetch_inst,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_pc4,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  logic [31:0] inst_p1;
  logic [31:0] pc_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;

  // ---- IF -> ID boundary ----
  // Bubble wins over load; neither means hold (stall). PC fields are kept on a
  // bubble since an invalid slot makes them don't-care downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_p1 <= NOP_INST;
      pc_p1   <= 32'd0;
      pc4_p1  <= 32'd0;
      vld_p1  <= 1'b0;
    end else if (bubble) begin
      inst_p1 <= NOP_INST;
      vld_p1  <= 1'b0;
    end else if (load) begin
      inst_p1 <= fetch_inst;
      pc_p1   <= fetch_pc;
      pc4_p1  <= fetch_pc4;
      vld_p1  <= 1'b1;
    end
  end

  assign ifid_inst  = inst_p1;
  assign ifid_pc    = pc_p1;
  assign ifid_pc4   = pc4_p1;
  assign ifid_valid = vld_p1;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC register, RUN/FAULT fetch FSM, valid-fetch
// counter and the IF/ID register. Priority per edge: reset, flush, stall,
// then normal fetch.
module if_fetch_unit
  import rv_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] IMEM_LIMIT = IMEM_LIMIT_DEF,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_pc,
  input  logic [31:0] i_instruccion,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_target,
  output logic [31:0] o_ifid_inst,
  output logic [31:0] o_ifid_pc,
  output logic [31:0] o_ifid_pc4,
  output logic        o_ifid_valid,
  output logic        o_fault,
  output logic        o_misaligned,
  output logic [31:0] o_fetch_cnt
);

  fetch_state_t state_p0;
  logic [31:0]  pc_p0;
  logic [31:0]  cnt_p0;
  logic         fault_p0;
  logic         mis_p0;

  logic         in_mem;
  logic         advance;
  logic         fetch_go;
  logic         fault_go;
  logic         bubble;
  logic [31:0]  pc4;

  // Edge decisions: fetch only when running inside memory; an out-of-range
  // fetch or a FAULT-state idle cycle produces a bubble instead.
  always_comb begin
    in_mem   = (pc_p0 < IMEM_LIMIT);
    advance  = !i_flush && !i_stall;
    fetch_go = advance && (state_p0 == ST_RUN) && in_mem;
    fault_go = advance && ((state_p0 == ST_FAULT) || !in_mem);
    bubble   = i_flush || fault_go;
    pc4      = pc_plus4(pc_p0);
  end

  // ---- PC / FSM stage ----
  // Fetch FSM with registered PC, counter, fault level and misalign pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_p0 <= ST_RUN;
      pc_p0    <= RESET_PC;
      cnt_p0   <= 32'd0;
      fault_p0 <= 1'b0;
      mis_p0   <= 1'b0;
    end else begin
      mis_p0 <= i_flush && (|i_target[1:0]);
      if (i_flush) begin
        state_p0 <= ST_RUN;
        pc_p0    <= word_align(i_target);
        fault_p0 <= 1'b0;
      end else if (fetch_go) begin
        pc_p0  <= pc4;
        cnt_p0 <= cnt_p0 + 32'd1;
      end else if (fault_go) begin
        state_p0 <= ST_FAULT;
        fault_p0 <= 1'b1;
      end
    end
  end

  ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid_reg (
    .clk        (i_clk),
    .rst        (i_rst),
    .load       (fetch_go),
    .bubble     (bubble),
    .fetch_inst (i_instruccion),
    .fetch_pc   (pc_p0),
    .fetch_pc4  (pc4),
    .ifid_inst  (o_ifid_inst),
    .ifid_pc    (o_ifid_pc),
    .ifid_pc4   (o_ifid_pc4),
    .ifid_valid (o_ifid_valid)
  );

  assign o_pc         = pc_p0;
  assign o_fault      = fault_p0;
  assign o_misaligned = mis_p0;
  assign o_fetch_cnt  = cnt_p0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios followed by randomized
// reset/flush/stall traffic, compared against a transaction-level model.
module tb_if_fetch_unit;

  localparam logic [31:0] LIMIT = 32'h0000_1000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] o_pc;
  logic [31:0] i_instruccion;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_target;
  logic [31:0] o_ifid_inst;
  logic [31:0] o_ifid_pc;
  logic [31:0] o_ifid_pc4;
  logic        o_ifid_valid;
  logic        o_fault;
  logic        o_misaligned;
  logic [31:0] o_fetch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4, m_cnt;
  logic        m_valid, m_fault, m_mis;

  // Instruction memory contents (MEM_INST): two fixed words, a hashed
  // pattern elsewhere, and a poison value outside memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h400) return 32'h0000_0433;
    if (a == 32'h404) return 32'h0000_04b3;
    if (a >= LIMIT)   return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A03;
  endfunction

  assign i_instruccion = mem_word(o_pc);

  if_fetch_unit dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_pc          (o_pc),
    .i_instruccion (i_instruccion),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_target      (i_target),
    .o_ifid_inst   (o_ifid_inst),
    .o_ifid_pc     (o_ifid_pc),
    .o_ifid_pc4    (o_ifid_pc4),
    .o_ifid_valid  (o_ifid_valid),
    .o_fault       (o_fault),
    .o_misaligned  (o_misaligned),
    .o_fetch_cnt   (o_fetch_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model one clock edge from the rules: reset, then redirect, then stall,
  // then fetch inside memory, otherwise sit in the fault condition.
  task automatic model_edge(input logic r, input logic f, input logic s, input logic [31:0] t);
    if (r) begin
      m_pc = 32'h400; m_inst = NOP; m_ipc = 0; m_ipc4 = 0;
      m_valid = 0; m_fault = 0; m_mis = 0; m_cnt = 0;
    end else if (f) begin
      m_pc = t & ~32'd3; m_valid = 0; m_inst = NOP; m_fault = 0;
      m_mis = (t % 4) != 0;
    end else if (s) begin
      m_mis = 0;
    end else if (!m_fault && m_pc < LIMIT) begin
      m_inst = mem_word(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 4;
      m_valid = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1; m_mis = 0;
    end else begin
      m_fault = 1; m_valid = 0; m_inst = NOP; m_mis = 0;
    end
  endtask

  task automatic compare_all();
    check("pc", o_pc, m_pc);
    check("ifid_inst", o_ifid_inst, m_inst);
    check("ifid_valid", {31'd0, o_ifid_valid}, {31'd0, m_valid});
    check("fault", {31'd0, o_fault}, {31'd0, m_fault});
    check("misaligned", {31'd0, o_misaligned}, {31'd0, m_mis});
    check("fetch_cnt", o_fetch_cnt, m_cnt);
    if (m_valid) begin
      check("ifid_pc", o_ifid_pc, m_ipc);
      check("ifid_pc4", o_ifid_pc4, m_ipc4);
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input logic r, input logic f, input logic s, input logic [31:0] t);
    i_rst = r; i_flush = f; i_stall = s; i_target = t;
    model_edge(r, f, s, t);
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_stall = 1'b0; i_target = 32'd0;

    // Reset and release
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_pc", o_pc, 32'h400);
    check("rst_valid", {31'd0, o_ifid_valid}, 32'd0);
    check("rst_inst", o_ifid_inst, NOP);
    check("rst_cnt", o_fetch_cnt, 32'd0);
    check("rst_ifid_pc", o_ifid_pc, 32'd0);

    // First fetch
    step(0, 0, 0, 0);
    check("f1_inst", o_ifid_inst, 32'h0000_0433);
    check("f1_ipc", o_ifid_pc, 32'h400);
    check("f1_ipc4", o_ifid_pc4, 32'h404);
    check("f1_pc", o_pc, 32'h404);
    check("f1_cnt", o_fetch_cnt, 32'd1);

    // Stall three cycles at 0x404, then resume
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'h1234_5678);
      check("stall_pc", o_pc, 32'h404);
      check("stall_inst", o_ifid_inst, 32'h0000_0433);
      check("stall_cnt", o_fetch_cnt, 32'd1);
    end
    step(0, 0, 0, 0);
    check("resume_inst", o_ifid_inst, 32'h0000_04b3);

    // Flush and stall together with a misaligned target
    step(0, 1, 1, 32'h406);
    check("fl_pc", o_pc, 32'h404);
    check("fl_valid", {31'd0, o_ifid_valid}, 32'd0);
    check("fl_inst", o_ifid_inst, NOP);
    check("fl_mis", {31'd0, o_misaligned}, 32'd1);
    step(0, 0, 0, 0);
    check("fl_mis_drop", {31'd0, o_misaligned}, 32'd0);

    // Run off the end of memory into FAULT and recover
    step(0, 1, 0, 32'hFFC);
    step(0, 0, 0, 0);
    check("end_pc", o_pc, 32'h1000);
    check("end_ipc", o_ifid_pc, 32'hFFC);
    step(0, 0, 0, 0);
    check("flt_on", {31'd0, o_fault}, 32'd1);
    check("flt_valid", {31'd0, o_ifid_valid}, 32'd0);
    check("flt_pc", o_pc, 32'h1000);
    step(0, 0, 0, 0);
    check("flt_hold_pc", o_pc, 32'h1000);
    step(0, 1, 0, 32'h400);
    check("flt_off", {31'd0, o_fault}, 32'd0);
    step(0, 0, 0, 0);
    check("flt_resume", o_ifid_inst, 32'h0000_0433);
    step(0, 0, 0, 0);
    check("at_408", o_pc, 32'h408);

    // Reset overriding a flush
    step(1, 1, 0, 32'h800);
    check("rst_ovr_pc", o_pc, 32'h400);
    check("rst_ovr_cnt", o_fetch_cnt, 32'd0);
    check("rst_ovr_valid", {31'd0, o_ifid_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, f, s;
      logic [31:0] t;
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) t = 32'hF00 + $urandom_range(0, 255);
      else                           t = $urandom_range(0, 32'h1100);
      step(r, f, s, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0400, boot fetch address and first PC after reset.
REQ-002 Parameter IMEM_LIMIT, 32'h0000_1000, first byte address outside instruction memory.
REQ-003 Parameter NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, synchronous and active-high.
REQ-006 o_pc  output  32  fetch address, drives instruction-memory i_pc.
REQ-007 i_instruccion  input  32  word returned combinationally by instruction memory for o_pc, same cycle.
REQ-008 i_stall  input  1  hazard stall from ID; hold PC and IF/ID.
REQ-009 i_flush  input  1  taken branch/jump from EX; redirect to i_target.
REQ-010 i_target  input  32  redirect address, sampled only when i_flush=1.
REQ-011 o_ifid_inst  output  32  IF/ID instruction.
REQ-012 o_ifid_pc  output  32  IF/ID PC of o_ifid_inst.
REQ-013 o_ifid_pc4  output  32  IF/ID o_ifid_pc+4.
REQ-014 o_ifid_valid  output  1  IF/ID holds a real instruction.
REQ-015 o_fault  output  1  level; high while in FAULT state.
REQ-016 o_misaligned  output  1  one-cycle pulse on redirect with i_target[1:0]!=0.
REQ-017 o_fetch_cnt  output  32  count of valid IF/ID loads.

Function
REQ-018 o_pc SHALL be a register; fetch-to-IF/ID latency SHALL be exactly one clock.
REQ-019 FSM SHALL have two states: RUN and FAULT.
REQ-020 Priority per edge SHALL be: i_rst > i_flush > i_stall > normal fetch.
REQ-021 Flush (any state): o_pc <= {i_target[31:2],2'b00}; o_ifid_valid <= 0; o_ifid_inst <= NOP_INST; state <= RUN; o_fetch_cnt unchanged.
REQ-022 Flush with i_target[1:0]!=0 SHALL assert o_misaligned for the following cycle only; otherwise o_misaligned SHALL be 0.
REQ-023 Stall (no flush): o_pc, all IF/ID outputs, o_fetch_cnt and state SHALL hold.
REQ-024 Normal in RUN with o_pc < IMEM_LIMIT: IF/ID <= {i_instruccion, o_pc, o_pc+4, valid=1}; o_pc <= o_pc+4; o_fetch_cnt += 1.
REQ-025 Normal in RUN with o_pc >= IMEM_LIMIT: state <= FAULT; o_ifid_valid <= 0; o_ifid_inst <= NOP_INST; o_pc held; i_instruccion ignored (may be X).
REQ-026 In FAULT without flush: o_pc held, o_ifid_valid=0, no count; only flush or reset exits.
REQ-027 PC increment and o_fetch_cnt SHALL wrap modulo 2^32; o_pc+4 from 32'hFFFF_FFFC SHALL give 0.
REQ-028 o_ifid_pc4 SHALL be 32-bit, carry discarded.

Reset
REQ-029 On i_rst=1 at an edge: o_pc=RESET_PC, state=RUN, o_ifid_inst=NOP_INST, o_ifid_pc=0, o_ifid_pc4=0, o_ifid_valid=0, o_fault=0, o_misaligned=0, o_fetch_cnt=0.
REQ-030 Reset asserted mid-operation SHALL override concurrent flush/stall and discard IF/ID contents.

Structure
REQ-031 RESET_PC, IMEM_LIMIT, NOP_INST defaults and state encoding SHALL live in shared package rv_if_pkg.
REQ-032 IF/ID register (load/hold/bubble control) SHALL be sub-module ifid_reg; PC, FSM and counter stay in if_fetch_unit.

Verification (bench instantiates MEM_INST: 0x400->32'h00000433, 0x404->32'h000004b3)
REQ-033 Reset, release -> o_pc=0x400, valid=0; after 1 edge ifid_inst=0x00000433, ifid_pc=0x400, ifid_pc4=0x404, o_pc=0x404, cnt=1; next edge ifid_inst=0x000004b3.
REQ-034 Stall 3 cycles at o_pc=0x404 -> o_pc, IF/ID, cnt unchanged all 3 cycles; resume loads 0x000004b3.
REQ-035 Flush+stall same edge, i_target=0x406 -> o_pc=0x404, valid=0, ifid_inst=0x00000013, o_misaligned=1 for one cycle.
REQ-036 Flush to 0xFFC, run -> after 0xFFC load o_pc=0x1000; next edge o_fault=1, valid=0, o_pc stays 0x1000; flush to 0x400 -> o_fault=0, fetch resumes.
REQ-037 i_rst pulsed while o_pc=0x408 and i_flush=1 -> o_pc=0x400, cnt=0, valid=0.
